// File: rtl/systolic_input_feeder_pkg.sv
// Types and helpers shared by the systolic input feeder and its delay lines.
package systolic_input_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Drain counter must hold the value ROWS itself.
  function automatic int drain_cnt_width(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/systolic_input_feeder_skew_delay_line.sv
// Fixed-latency shift register carrying {valid, first, data} for one array row.
module systolic_input_feeder_skew_delay_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    assign q_o = d_i;
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: the stages are reset on purpose -- a reset mid-tile must discard skewed
    // data, so this register array cannot be left as an unreset memory.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// Skews incoming row vectors onto the west edge of a systolic array, row r delayed
// by r cycles, with a weight-switch strobe one cycle ahead of each row's first element.
module systolic_input_feeder
  import systolic_input_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [ROWS*DATA_WIDTH-1:0] out_input,
  output logic [ROWS-1:0]            out_valid,
  output logic [ROWS-1:0]            out_switch,
  output logic                       busy,
  output logic                       tile_done
);

  localparam int            CW         = drain_cnt_width(ROWS);
  localparam int            LW         = DATA_WIDTH + 2;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(ROWS);
  localparam logic [CW-1:0] DRAIN_ONE  = CW'(1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              drain_q, drain_d;
  logic                       tile_done_q, tile_done_d;
  logic                       accept;

  logic                       s1_valid_q, s1_first_q;
  logic [ROWS*DATA_WIDTH-1:0] s1_data_q;

  logic [ROWS-1:0]            dl_valid, dl_first;
  logic [ROWS*DATA_WIDTH-1:0] dl_data;

  logic [ROWS-1:0]            out_valid_q;
  logic [ROWS*DATA_WIDTH-1:0] out_input_q;

  assign in_ready  = (state_q != FLUSH) && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign tile_done = tile_done_q;

  // NOTE: every output of this block is given a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    tile_done_d = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = FLUSH;
            drain_d = DRAIN_LOAD;
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        drain_d = drain_q - DRAIN_ONE;
        if (drain_q == DRAIN_ONE) begin
          state_d     = IDLE;
          tile_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Stage 1: the first flag is only raised for the vector that opens a tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_first_q <= accept && (state_q == IDLE);
      s1_data_q  <= accept ? in_data : '0;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [LW-1:0] dl_in, dl_out;

    assign dl_in = {s1_valid_q, s1_first_q, s1_data_q[r*DATA_WIDTH +: DATA_WIDTH]};

    systolic_input_feeder_skew_delay_line #(
      .DEPTH (r),
      .WIDTH (LW)
    ) u_skew (
      .clk (clk),
      .rst (rst),
      .d_i (dl_in),
      .q_o (dl_out)
    );

    assign dl_valid[r]                            = dl_out[LW-1];
    assign dl_first[r]                            = dl_out[LW-2];
    assign dl_data[r*DATA_WIDTH +: DATA_WIDTH]    = dl_out[DATA_WIDTH-1:0];
  end

  // The switch leaves the delay line one stage before its data reaches the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_input_q <= '0;
    end else begin
      out_valid_q <= dl_valid;
      for (int r = 0; r < ROWS; r++) begin
        out_input_q[r*DATA_WIDTH +: DATA_WIDTH] <=
          dl_valid[r] ? dl_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
  end

  assign out_switch = dl_first;
  assign out_valid  = out_valid_q;
  assign out_input  = out_input_q;

endmodule
